spi_master_arbiter: RTL



---
 rtl/spi_master_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master between NUM_REQ requesters.
// Optional WAIT-state abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk_m,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rsp_data,
  output logic                  busy,
  output logic                  spi_start,
  output logic [DW-1:0]         spi_data_in,
  input  logic                  spi_finish,
  input  logic [DW-1:0]         spi_data_out,
  output logic                  timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       idx_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [DW-1:0]       rsp_q;
  logic [DW-1:0]       sdi_q;
  logic                start_q;

  logic [DW-1:0]       req_word [NUM_REQ];
  logic                win_valid_d;
  logic [IW-1:0]       win_idx_d;
  logic                expire_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = ptr_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[IW'((int'(ptr_q) + k) % NUM_REQ)]) begin
        win_valid_d = 1'b1;
        win_idx_d   = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tcnt_q;
  logic          terr_q;

  assign expire_d = (tcnt_q == CW'(TIMEOUT - 1));

  // terr_q rises on the same edge that raises done, and clears with it.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      terr_q <= (state_q == WAIT) && !spi_finish && expire_d;
      if (state_q == LAUNCH) begin
        tcnt_q <= '0;
      end else if (state_q == WAIT) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign timeout_err = terr_q;
`else
  assign expire_d    = 1'b0;
  assign timeout_err = 1'b0;

  // TIMEOUT only drives hardware with the abort counter; this empty block keeps it referenced.
  if (TIMEOUT < 1) begin : g_timeout_range
  end
`endif

  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rsp_q   <= '0;
      sdi_q   <= '0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            gnt_q   <= NUM_REQ'(1) << win_idx_d;
            sdi_q   <= req_word[win_idx_d];
            start_q <= 1'b1;
            idx_q   <= win_idx_d;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (spi_finish || expire_d) begin
            rsp_q   <= spi_finish ? spi_data_out : '0;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            ptr_q   <= idx_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_data    = rsp_q;
  assign spi_start   = start_q;
  assign spi_data_in = sdi_q;
  assign busy        = (state_q != IDLE);

endmodule
